// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if
//   Groups the handshake and datapath-control signals of the AES-128
//   word-serial round sequencer.
//   master : block-level requester / datapath side (drives start, key_ready,
//            stall, out_ready; observes the sequencer outputs)
//   slave  : the sequencer itself
interface aes_round_ctrl_if;
  logic       start;
  logic       key_ready;
  logic       stall;
  logic       out_ready;
  logic       busy;
  logic [3:0] round_idx;
  logic [1:0] word_idx;
  logic [5:0] rk_addr;
  logic       in_sel;
  logic       en_sub;
  logic       en_shift;
  logic       en_mix;
  logic       en_ark;
  logic       state_we;
  logic       out_valid;

  modport master (
    output start, key_ready, stall, out_ready,
    input  busy, round_idx, word_idx, rk_addr, in_sel,
           en_sub, en_shift, en_mix, en_ark, state_we, out_valid
  );

  modport slave (
    input  start, key_ready, stall, out_ready,
    output busy, round_idx, word_idx, rk_addr, in_sel,
           en_sub, en_shift, en_mix, en_ark, state_we, out_valid
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl
//   Sequencer for a 32-bit word-serial AES-128 encryption datapath. Walks the
//   datapath through initial AddRoundKey, then SubBytes/ShiftRows/MixColumns/
//   AddRoundKey per round (no MixColumns in the last round), and presents the
//   ciphertext one word at a time. Performs no data arithmetic.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - aes_round_ctrl_if.slave: start/key_ready request, stall freeze,
//          out_valid/out_ready ciphertext handshake, phase enables,
//          round/word indices and round-key word address
//
// state | meaning
// IDLE  | waiting for start with key_ready
// ARK0  | initial AddRoundKey on plaintext words 0..3 (in_sel=1)
// SUB   | SubBytes on words 0..3
// SHIFT | ShiftRows on the whole state, one cycle
// MIX   | MixColumns on words 0..3 (rounds 1..NR-1 only)
// ARK   | AddRoundKey on words 0..3
// OUT   | ciphertext words 0..3 presented with out_valid
module aes_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic              clk,
  input  logic              rst,
  aes_round_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARK0  = 3'd1,
    SUB   = 3'd2,
    SHIFT = 3'd3,
    MIX   = 3'd4,
    ARK   = 3'd5,
    OUT   = 3'd6
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [1:0] word_q,  word_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      word_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (bus.start && bus.key_ready) begin
          state_d = ARK0;
          round_d = 4'd0;
          word_d  = 2'd0;
        end
      end
      ARK0: begin
        if (!bus.stall) begin
          word_d = word_q + 2'd1;
          if (word_q == 2'd3) begin
            round_d = 4'd1;
            state_d = SUB;
          end
        end
      end
      SUB: begin
        if (!bus.stall) begin
          word_d = word_q + 2'd1;
          if (word_q == 2'd3) state_d = SHIFT;
        end
      end
      SHIFT: begin
        // word_q stays 0 here; last round skips MixColumns
        if (!bus.stall) state_d = (round_q < LAST_ROUND) ? MIX : ARK;
      end
      MIX: begin
        if (!bus.stall) begin
          word_d = word_q + 2'd1;
          if (word_q == 2'd3) state_d = ARK;
        end
      end
      ARK: begin
        if (!bus.stall) begin
          word_d = word_q + 2'd1;
          if (word_q == 2'd3) begin
            if (round_q < LAST_ROUND) begin
              round_d = round_q + 4'd1;
              state_d = SUB;
            end else begin
              state_d = OUT;
            end
          end
        end
      end
      OUT: begin
        // round_q holds NR while the ciphertext drains
        if (bus.out_ready) begin
          word_d = word_q + 2'd1;
          if (word_q == 2'd3) begin
            state_d = IDLE;
            round_d = 4'd0;
            word_d  = 2'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        round_d = 4'd0;
        word_d  = 2'd0;
      end
    endcase
  end

  // stall masks every datapath write combinationally in the cycle it is seen
  logic go;
  assign go = ~bus.stall;

  assign bus.busy      = (state_q != IDLE);
  assign bus.round_idx = round_q;
  assign bus.word_idx  = word_q;
  assign bus.rk_addr   = {round_q, word_q};
  assign bus.in_sel    = (state_q == ARK0) && go;
  assign bus.en_sub    = (state_q == SUB) && go;
  assign bus.en_shift  = (state_q == SHIFT) && go;
  assign bus.en_mix    = (state_q == MIX) && go;
  assign bus.en_ark    = ((state_q == ARK0) || (state_q == ARK)) && go;
  assign bus.state_we  = bus.en_sub | bus.en_shift | bus.en_mix | bus.en_ark;
  assign bus.out_valid = (state_q == OUT);

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_round_ctrl_if bus ();

  aes_round_ctrl #(.NR(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic       busy;
    logic [3:0] rnd;
    logic [1:0] wd;
    logic [5:0] rk;
    logic       in_sel;
    logic       sub;
    logic       shift;
    logic       mix;
    logic       ark;
    logic       ov;
    bit         chk_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int c, logic b, int r, int w, int k, logic is,
                              logic s, logic sh, logic m, logic a, logic o,
                              bit cc);
    vec_t v;
    v.cyc = c; v.busy = b; v.rnd = 4'(r); v.wd = 2'(w); v.rk = 6'(k);
    v.in_sel = is; v.sub = s; v.shift = sh; v.mix = m; v.ark = a; v.ov = o;
    v.chk_cnt = cc;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_vec(input vec_t v);
    chk("busy", int'(bus.busy), int'(v.busy));
    chk("word_idx", int'(bus.word_idx), int'(v.wd));
    if (v.chk_cnt) begin
      chk("round_idx", int'(bus.round_idx), int'(v.rnd));
      chk("rk_addr", int'(bus.rk_addr), int'(v.rk));
    end
    chk("in_sel", int'(bus.in_sel), int'(v.in_sel));
    chk("en_sub", int'(bus.en_sub), int'(v.sub));
    chk("en_shift", int'(bus.en_shift), int'(v.shift));
    chk("en_mix", int'(bus.en_mix), int'(v.mix));
    chk("en_ark", int'(bus.en_ark), int'(v.ark));
    chk("out_valid", int'(bus.out_valid), int'(v.ov));
  endtask

  // accept a start: inputs present in cycle 0, cycle 1 begins after the edge
  task automatic kick();
    bus.start = 1'b1;
    bus.key_ready = 1'b1;
    cyc = 0;
    next_cycle();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    bus.stall = 1'b0;
    bus.start = 1'b0;
    while (bus.busy && n < bound) begin
      next_cycle();
      n++;
    end
    chk("idle_within_bound", int'(bus.busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_sub, n_shift, n_mix, n_ark, n_we, n_multi;

  initial begin
    bus.start = 1'b0;
    bus.key_ready = 1'b0;
    bus.stall = 1'b0;
    bus.out_ready = 1'b1;

    // reset state
    #2;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_rk_addr", int'(bus.rk_addr), 0);
    chk("rst_round", int'(bus.round_idx), 0);
    chk("rst_we", int'(bus.state_we), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    next_cycle();

    // ---- full run, table-driven checkpoints ----
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1+i, 1, 0, i, i, 1, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(5,   1, 1, 0, 4, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(9,   1, 1, 0, 4, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(10,  1, 1, 0, 4, 0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(14,  1, 1, 0, 4, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(17,  1, 1, 3, 7, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(18,  1, 2, 0, 8, 0, 1, 0, 0, 0, 0, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(122+i, 1, 10, i, 40+i, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(126, 1, 10, 0, 40, 0, 0, 1, 0, 0, 0, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(127+i, 1, 10, i, 40+i, 0, 0, 0, 0, 1, 0, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(131+i, 1, 0, i, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(135, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    n_sub = 0; n_shift = 0; n_mix = 0; n_ark = 0; n_we = 0; n_multi = 0;
    begin
      int j;
      j = 0;
      kick();
      while (cyc <= 135) begin
        #1;
        n_sub   += int'(bus.en_sub);
        n_shift += int'(bus.en_shift);
        n_mix   += int'(bus.en_mix);
        n_ark   += int'(bus.en_ark);
        n_we    += int'(bus.state_we);
        if ((int'(bus.en_sub) + int'(bus.en_shift) + int'(bus.en_mix) + int'(bus.en_ark)) > 1)
          n_multi++;
        if (j < vecs.size() && vecs[j].cyc == cyc) begin
          apply_vec(vecs[j]);
          j++;
        end
        next_cycle();
      end
      chk("vectors_applied", j, vecs.size());
    end
    chk("count_en_sub", n_sub, 40);
    chk("count_en_shift", n_shift, 10);
    chk("count_en_mix", n_mix, 36);
    chk("count_en_ark", n_ark, 44);
    chk("count_state_we", n_we, 130);
    chk("multi_enable_cycles", n_multi, 0);

    // ---- start without key_ready is ignored ----
    bus.start = 1'b1;
    bus.key_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      #1;
      chk("nokey_busy", int'(bus.busy), 0);
    end
    bus.key_ready = 1'b1;
    #1;
    chk("nokey_busy_before_edge", int'(bus.busy), 0);
    cyc = 0;
    next_cycle();
    bus.start = 1'b0;
    #1;
    chk("key_busy", int'(bus.busy), 1);
    chk("key_en_ark", int'(bus.en_ark), 1);
    chk("key_in_sel", int'(bus.in_sel), 1);
    chk("key_rk_addr", int'(bus.rk_addr), 0);
    wait_idle(200);

    // ---- stall in MIX of round 2 at word 1, cycles 24..26 ----
    kick();
    while (cyc <= 135) begin
      bus.stall = (cyc >= 24 && cyc <= 26);
      #1;
      if (cyc == 23) begin
        chk("pre_stall_mix", int'(bus.en_mix), 1);
        chk("pre_stall_rk", int'(bus.rk_addr), 8);
      end
      if (cyc >= 24 && cyc <= 26) begin
        chk("stall_en_mix", int'(bus.en_mix), 0);
        chk("stall_we", int'(bus.state_we), 0);
        chk("stall_word", int'(bus.word_idx), 1);
        chk("stall_rk", int'(bus.rk_addr), 9);
      end
      if (cyc == 27) begin
        chk("post_stall_mix", int'(bus.en_mix), 1);
        chk("post_stall_rk", int'(bus.rk_addr), 9);
      end
      if (cyc == 133) chk("stall_ov_133", int'(bus.out_valid), 0);
      if (cyc == 134) chk("stall_ov_134", int'(bus.out_valid), 1);
      next_cycle();
    end
    wait_idle(20);

    // ---- OUT backpressure, start pulses ignored ----
    kick();
    while (cyc <= 140) begin
      bus.out_ready = !(cyc >= 131 && cyc <= 134);
      bus.start = (cyc >= 131 && cyc <= 134);
      #1;
      if (cyc >= 131 && cyc <= 135) begin
        chk("bp_out_valid", int'(bus.out_valid), 1);
        chk("bp_word_hold", int'(bus.word_idx), 0);
      end
      if (cyc >= 136 && cyc <= 138) begin
        chk("bp_out_valid_run", int'(bus.out_valid), 1);
        chk("bp_word_run", int'(bus.word_idx), cyc - 135);
      end
      if (cyc >= 139) begin
        chk("bp_busy_done", int'(bus.busy), 0);
        chk("bp_ov_done", int'(bus.out_valid), 0);
      end
      next_cycle();
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;

    // ---- async reset mid round 5 ----
    kick();
    while (cyc < 60) next_cycle();
    #1;
    chk("r5_round", int'(bus.round_idx), 5);
    chk("r5_rk", int'(bus.rk_addr), 23);
    rst = 1'b1;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_we", int'(bus.state_we), 0);
    chk("arst_en_sub", int'(bus.en_sub), 0);
    chk("arst_out_valid", int'(bus.out_valid), 0);
    chk("arst_round", int'(bus.round_idx), 0);
    chk("arst_rk", int'(bus.rk_addr), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    next_cycle();
    kick();
    #1;
    chk("restart_rk", int'(bus.rk_addr), 0);
    chk("restart_en_ark", int'(bus.en_ark), 1);
    chk("restart_in_sel", int'(bus.in_sel), 1);
    wait_idle(200);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequencer for the 32-bit word-serial AES-128 encryption datapath.
- Steps the datapath through its phases in order: initial AddRoundKey, then per round SubBytes, ShiftRows, MixColumns and AddRoundKey.
- Generates the word index and the round-key word address consumed by the key schedule store.
- Sits between the block-level start/output handshake and the datapath; performs no data arithmetic itself.

Parameters:
NR, 10, number of AES rounds (legal range 1..10; the AES-128 value is 10).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request to encrypt the plaintext currently presented to the datapath
key_ready  in  1  round-key store holds a valid expanded key
stall  in  1  freeze request from the datapath
busy  out  1  controller not in IDLE
round_idx  out  4  current round, 0..NR
word_idx  out  2  current state column, 0..3
rk_addr  out  6  round-key word address, round_idx*4 + word_idx
in_sel  out  1  datapath takes the plaintext word instead of the state word
en_sub  out  1  SubBytes on the word at word_idx
en_shift  out  1  ShiftRows on the whole state
en_mix  out  1  MixColumns on the word at word_idx
en_ark  out  1  AddRoundKey on the word at word_idx with the key word at rk_addr
state_we  out  1  state register write; equals en_sub|en_shift|en_mix|en_ark
out_valid  out  1  ciphertext word at word_idx is valid
out_ready  in  1  consumer accepts the ciphertext word

Behaviour:
- Reset (async, any state, including mid-block):
  - state goes to IDLE immediately.
  - round_idx=0, word_idx=0, rk_addr=0.
  - All enables, in_sel, state_we, busy and out_valid are 0.
  - Any partial block is discarded.
- States: IDLE, ARK0, SUB, SHIFT, MIX, ARK, OUT. All outputs are decoded from registered state and counters, except the stall gating described below.
- IDLE:
  - A start is accepted on a rising edge where start=1 and key_ready=1.
  - On acceptance: go to ARK0 with round_idx=0 and word_idx=0.
  - start with key_ready=0 is ignored and not remembered.
  - start outside IDLE is ignored.
- ARK0: en_ark=1 and in_sel=1 for 4 cycles (word 0..3). After word 3: round_idx becomes 1 and the state goes to SUB.
- SUB: en_sub=1 for 4 cycles (word 0..3), then SHIFT.
- SHIFT: en_shift=1 for 1 cycle. word_idx is held at 0. Next state is MIX if round_idx<NR, otherwise ARK.
- MIX: en_mix=1 for 4 cycles, then ARK.
- ARK: en_ark=1 for 4 cycles. After word 3:
  - if round_idx<NR: increment round_idx and go to SUB;
  - otherwise: go to OUT with word_idx=0.
- word_idx wraps 3->0 at every phase change. rk_addr is always round_idx*4+word_idx (range 0..43).
- OUT:
  - out_valid=1 while presenting word_idx.
  - The word advances on a cycle where out_valid and out_ready are both 1.
  - After word 3 is accepted, the next state is IDLE with round_idx=0 and word_idx=0.
  - No state_we or enables are asserted in OUT.
- stall:
  - In ARK0/SUB/SHIFT/MIX/ARK, stall=1 holds state and counters, and forces en_*, in_sel and state_we to 0 combinationally in that cycle.
  - stall has no effect in IDLE or OUT.
- busy=1 in every state except IDLE.
- Latency with no stall and start accepted at edge 0:
  - Enable cycles occupy cycles 1..13*NR.
  - out_valid first rises in cycle 13*NR+1, which is 131 for NR=10.
  - For NR=10: ARK0 occupies cycles 1-4, rounds 1-9 occupy cycles 5-121, and round 10 SUB/SHIFT/ARK occupies cycles 122-125/126/127-130.
- Exactly one of en_sub/en_shift/en_mix/en_ark is high in any cycle, or none.

Test Plan:
- Reset, then start=1 with key_ready=1, no stall, out_ready=1 -> ARK0 with rk_addr 0,1,2,3 and in_sel=1 in cycles 1-4. In cycles 122-130: en_sub x4, en_shift x1, en_ark x4 with rk_addr 40..43 and no en_mix. out_valid rises in cycle 131, word_idx 0..3 over cycles 131-134, busy=0 in cycle 135.
- Full run -> exactly 40 en_sub, 10 en_shift, 36 en_mix and 44 en_ark cycles; state_we count 130; never more than one en_* high at once.
- start=1 with key_ready=0 for 5 cycles, then key_ready=1 -> busy stays 0 until the edge where key_ready=1; ARK0 begins the next cycle.
- stall=1 for 3 cycles while in MIX of round 2 at word 1 -> en_mix=0 and word_idx/rk_addr frozen at 1/9 during the stall; completion is delayed by exactly 3 cycles (out_valid in cycle 134).
- In OUT, out_ready=0 for 4 cycles and then 1 -> out_valid stays 1 with word_idx=0 held; then words 1..3 are accepted on consecutive cycles; start pulses during OUT are ignored.
- rst asserted asynchronously mid-round 5 -> busy, en_* and out_valid are 0 immediately, round_idx=0; after release, a new start yields rk_addr=0 in cycle 1.
